// File: rtl/flex_counter_pkg.sv
// Shared types for the multi-channel flexible counter.
// Terminal-mode and per-channel state encodings plus the mode decoder.
package flex_counter_pkg;

   typedef enum logic [1:0] {
      WRAP    = 2'b00,
      SAT     = 2'b01,
      ONESHOT = 2'b10
   } mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   // The unused encoding 2'b11 behaves as WRAP.
   function automatic mode_t decode_mode(input logic [1:0] m);
      return (m == 2'b11) ? WRAP : mode_t'(m);
   endfunction

endpackage

// File: rtl/flex_counter_ch.sv
// One counter channel: IDLE/RUN/DONE state, ranged up/down count with clamp,
// terminal flag, wrap pulse and carry. All outputs registered except adv/carry/next-state taps.
module flex_counter_ch
   import flex_counter_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clear_i,
   input  logic         load_i,
   input  logic         en_i,
   input  logic         adv_ok_i,
   input  logic         dir_i,
   input  mode_t        mode_i,
   input  logic         self_done_en_i,
   input  logic         done_set_i,
   input  logic [W-1:0] step_i,
   input  logic [W-1:0] lo_i,
   input  logic [W-1:0] hi_i,
   output logic         adv_o,
   output logic         carry_o,
   output logic         at_term_o,
   output logic         nxt_term_o,
   output logic         run_d_o,
   output logic [W-1:0] count_o,
   output logic         flag_o,
   output logic         wrap_o,
   output logic         done_o
);

   logic [W-1:0] count_q, count_d;
   state_t       state_q, state_d;
   logic         flag_q, flag_d;
   logic         wrap_q, wrap_d;

   logic [W-1:0] origin, term, step_eff, stepped;
   logic [W:0]   sum, diff;
   logic         at_term, adv;

   always_comb begin
      origin   = dir_i ? hi_i : lo_i;
      term     = dir_i ? lo_i : hi_i;
      step_eff = (step_i == '0) ? {{(W-1){1'b0}}, 1'b1} : step_i;
      at_term  = dir_i ? (count_q <= lo_i) : (count_q >= hi_i);
      adv      = en_i && (state_q == RUN) && adv_ok_i;

      // Extra bit catches overflow going up and borrow going down; both clamp to terminal.
      sum  = {1'b0, count_q} + {1'b0, step_eff};
      diff = {1'b0, count_q} - {1'b0, step_eff};
      if (dir_i)
         stepped = (diff[W] || (diff[W-1:0] <= lo_i)) ? lo_i : diff[W-1:0];
      else
         stepped = (sum >= {1'b0, hi_i}) ? hi_i : sum[W-1:0];

      count_d = count_q;
      wrap_d  = 1'b0;
      if (clear_i) begin
         count_d = '0;
      end else if (load_i) begin
         count_d = origin;
      end else if (adv) begin
         if (at_term) begin
            if (mode_i == WRAP) begin
               count_d = origin;
               wrap_d  = 1'b1;
            end
         end else begin
            count_d = stepped;
         end
      end

      state_d = state_q;
      if (clear_i)
         state_d = IDLE;
      else if (load_i)
         state_d = RUN;
      else if ((state_q == RUN) &&
               ((self_done_en_i && adv && (at_term || (stepped == term))) || done_set_i))
         state_d = DONE;

      nxt_term_o = (count_d == term);
      flag_d     = !clear_i && nxt_term_o;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
         state_q <= IDLE;
         flag_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         state_q <= state_d;
         flag_q  <= flag_d;
         wrap_q  <= wrap_d;
      end
   end

   assign adv_o     = adv;
   assign carry_o   = adv && at_term;
   assign at_term_o = at_term;
   assign run_d_o   = (state_d == RUN);
   assign count_o   = count_q;
   assign flag_o    = flag_q;
   assign wrap_o    = wrap_q;
   assign done_o    = (state_q == DONE);

endmodule

// File: rtl/flex_counter_mc.sv
// NUM_CH flexible counters, optionally chained into a mixed-radix counter via a
// combinational carry chain; chain-terminal hold/done logic and registered busy.
module flex_counter_mc
   import flex_counter_pkg::*;
#(
   parameter int NUM_CNT_BITS = 8,
   parameter int NUM_CH       = 2,
   parameter int CASCADE      = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clear,
   input  logic                           load,
   input  logic [NUM_CH-1:0]              count_enable,
   input  logic                           dir,
   input  logic [1:0]                     mode,
   input  logic [NUM_CNT_BITS-1:0]        step,
   input  logic [NUM_CH*NUM_CNT_BITS-1:0] start_val,
   input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
   output logic [NUM_CH-1:0]              rollover_flag,
   output logic [NUM_CH-1:0]              wrap_pulse,
   output logic [NUM_CH-1:0]              done,
   output logic                           busy
);

   localparam int W = NUM_CNT_BITS;

   mode_t             mode_eff;
   logic [NUM_CH-1:0] adv_v, at_term_v, nxt_term_v, run_d_v;
   logic              hold, done_set, self_done_en;
   logic              busy_q;

   assign mode_eff     = decode_mode(mode);
   assign self_done_en = (CASCADE == 0) && (mode_eff == ONESHOT);

   // A saturated/finished chain freezes as a whole once every channel sits at terminal.
   assign hold     = (CASCADE != 0) && (mode_eff != WRAP) && (&at_term_v);
   assign done_set = (CASCADE != 0) && (mode_eff == ONESHOT) && (|adv_v) && (&nxt_term_v);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic  cin;
      logic  carry;
      mode_t ch_mode;

      if (i == 0 || CASCADE == 0) begin : g_head
         assign cin = 1'b1;
      end else begin : g_link
         assign cin = g_ch[i-1].carry;
      end

      assign ch_mode = (CASCADE != 0 && i < NUM_CH - 1) ? WRAP : mode_eff;

      flex_counter_ch #(.W(W)) u_ch (
         .clk_i          (clk),
         .rst_i          (rst),
         .clear_i        (clear),
         .load_i         (load),
         .en_i           (count_enable[i]),
         .adv_ok_i       (cin && !hold),
         .dir_i          (dir),
         .mode_i         (ch_mode),
         .self_done_en_i (self_done_en),
         .done_set_i     (done_set),
         .step_i         (step),
         .lo_i           (start_val[i*W +: W]),
         .hi_i           (rollover_val[i*W +: W]),
         .adv_o          (adv_v[i]),
         .carry_o        (carry),
         .at_term_o      (at_term_v[i]),
         .nxt_term_o     (nxt_term_v[i]),
         .run_d_o        (run_d_v[i]),
         .count_o        (count_out[i*W +: W]),
         .flag_o         (rollover_flag[i]),
         .wrap_o         (wrap_pulse[i]),
         .done_o         (done[i])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         busy_q <= 1'b0;
      else
         busy_q <= |run_d_v;
   end

   assign busy = busy_q;

endmodule
